sent_tx_crc_engine: RTL
=======================

SENT_TX_CRC_ENGINE -- requirements
Module: sent_tx_crc_engine

Interface
REQ-001 SHALL have parameter SEED4, default 4'b0101, meaning initial seed for all 4-bit CRC modes.
REQ-002 SHALL have parameter POLY4, default 5'b11101, meaning 4-bit generator x^4+x^3+x^2+1.
REQ-003 SHALL have parameter SEED6, default 6'b010101, meaning initial seed for the enhanced 6-bit CRC.
REQ-004 SHALL have parameter POLY6, default 7'b1011001, meaning 6-bit generator x^6+x^4+x^3+1.
REQ-005 SHALL have port clk_tx, input, 1 bit: single clock; all state on its rising edge.
REQ-006 SHALL have port reset_n_tx, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start_crc, input, 1 bit: request; sampled only in IDLE.
REQ-008 SHALL have port enable_crc_gen, input, 3 bits: mode, captured with start_crc.
REQ-009 SHALL have port data_gen_crc, input, 24 bits: data nibbles, captured with start_crc; nibble 0 is the MSB nibble of the used field.
REQ-010 SHALL have port crc_exp, input, 6 bits: received CRC for comparison, captured with start_crc.
REQ-011 SHALL have port busy_crc, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port done_crc, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port crc_gen, output, 6 bits: result; bits [5:4] are 0 in 4-bit modes.
REQ-014 SHALL have port crc_match, output, 1 bit: crc_gen == captured crc_exp (all 6 bits).
REQ-015 SHALL have port mode_err, output, 1 bit: captured mode was not legal.

Function
REQ-016 SHALL support these modes: 3'b011 and 3'b100 = 3 nibbles (data[11:0]); 3'b010 = 4 nibbles (data[15:0]); 3'b001 = 6 nibbles (data[23:0]), all with SEED4/POLY4; 3'b101 = enhanced, 24 bits with SEED6/POLY6.
REQ-017 SHALL produce a result equal to the remainder of {seed, used data bits, k zero bits} modulo the polynomial, with k=4 for 4-bit modes and k=6 for enhanced.
REQ-018 SHALL use the FSM states IDLE, SHIFT, FLUSH and DONE.
REQ-019 IDLE SHALL, on start_crc=1 with a legal mode, capture all inputs, preload the seed and go to SHIFT.
REQ-020 SHIFT SHALL consume exactly one data nibble per cycle, MSB nibble first, for N cycles (N = 3, 4 or 6; 6 for enhanced), then go to FLUSH.
REQ-021 FLUSH SHALL process the k augmentation zeros in one cycle, then go to DONE.
REQ-022 DONE SHALL last one cycle, assert done_crc, and return to IDLE.
REQ-023 done_crc SHALL rise exactly N+2 cycles after the cycle in which start_crc was accepted.
REQ-024 crc_gen, crc_match and mode_err SHALL update on entry to DONE and hold until the next DONE or reset.
REQ-025 start_crc while busy_crc=1 SHALL be ignored, with no effect on the running computation.
REQ-026 start_crc during DONE SHALL be ignored; start_crc in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back throughput N+3 cycles).
REQ-027 An illegal mode (000, 110, 111) at start SHALL go directly to DONE on the next cycle with crc_gen=0, crc_match=0 and mode_err=1.
REQ-028 Changes to data_gen_crc, enable_crc_gen or crc_exp after capture SHALL NOT affect the result.

Reset
REQ-029 reset_n_tx=0 SHALL immediately force IDLE, clear the nibble counter and shift register, and drive busy_crc=0, done_crc=0, crc_gen=0, crc_match=0 and mode_err=0.
REQ-030 Reset asserted mid-SHIFT or mid-FLUSH SHALL abort the computation with no done_crc pulse.
REQ-031 After release, the first accepted start_crc SHALL behave exactly as from power-up.

Verification
REQ-032 Mode 3'b011, data 0x000, crc_exp 0x9 -> done_crc at start+5, crc_gen=0x09, crc_match=1.
REQ-033 Mode 3'b100, data 0x001 -> crc_gen=0x04; mode 3'b010, data 0x0000 -> crc_gen=0x0C; mode 3'b001, data 0x000000 -> crc_gen=0x05 with done_crc at start+8.
REQ-034 Mode 3'b101, data 0x000000, crc_exp 0x00 -> crc_gen=0x26, crc_match=0, mode_err=0.
REQ-035 Mode 3'b110 -> done_crc at start+1, crc_gen=0, mode_err=1; a second start_crc pulsed during any busy cycle -> exactly one done_crc pulse and an unchanged result.
REQ-036 reset_n_tx pulsed low in SHIFT cycle 2 -> all outputs 0 asynchronously, no done_crc; a new mode 3'b011 start on data 0x000 -> crc_gen=0x09.
REQ-037 Random regression: all legal modes, random data, back-to-back starts -> results match a bitwise long-division reference model, with done_crc spacing N+3.

Source files
------------

// File: rtl/sent_tx_crc_engine.sv
// SENT transmit CRC engine: nibble-serial 4-bit and enhanced 6-bit CRC
// with a received-CRC comparison and an illegal-mode flag.
module sent_tx_crc_engine #(
    parameter logic [3:0] SEED4 = 4'b0101,
    parameter logic [4:0] POLY4 = 5'b11101,
    parameter logic [5:0] SEED6 = 6'b010101,
    parameter logic [6:0] POLY6 = 7'b1011001
) (
    input  logic        clk_tx,
    input  logic        reset_n_tx,
    input  logic        start_crc,
    input  logic [2:0]  enable_crc_gen,
    input  logic [23:0] data_gen_crc,
    input  logic [5:0]  crc_exp,
    output logic        busy_crc,
    output logic        done_crc,
    output logic [5:0]  crc_gen,
    output logic        crc_match,
    output logic        mode_err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLUSH,
        DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  n_q;
    logic        enh_q;
    logic [5:0]  sr_q;
    logic [23:0] data_q;
    logic [5:0]  exp_q;
    logic [5:0]  crc_q;
    logic        match_q;
    logic        err_q;

    logic        legal;
    logic        enh;
    logic [2:0]  n_dec;
    logic [23:0] data_algn;
    logic [5:0]  shift_res;
    logic [5:0]  flush_res;
    logic        last_nib;

    // Feed the low nbits of din, MSB first, through the division register.
    function automatic logic [5:0] crc_feed(
        input logic [5:0] r,
        input logic [5:0] din,
        input logic       e,
        input logic [2:0] nbits
    );
        logic [5:0] c;
        logic       msb;
        c = r;
        for (int i = 5; i >= 0; i--) begin
            if (i < int'(nbits)) begin
                if (e) begin
                    msb = c[5];
                    c = {c[4:0], din[i]} ^ (msb ? POLY6[5:0] : 6'd0);
                end else begin
                    msb = c[3];
                    c = {2'b00, c[2:0], din[i]}
                      ^ (msb ? {2'b00, POLY4[3:0]} : 6'd0);
                end
            end
        end
        return c;
    endfunction

    // Left-align the used field so nibble 0 always sits in [23:20].
    always_comb begin
        legal     = 1'b1;
        enh       = 1'b0;
        n_dec     = 3'd6;
        data_algn = data_gen_crc;
        case (enable_crc_gen)
            3'b011, 3'b100: begin
                n_dec     = 3'd3;
                data_algn = {data_gen_crc[11:0], 12'd0};
            end
            3'b010: begin
                n_dec     = 3'd4;
                data_algn = {data_gen_crc[15:0], 8'd0};
            end
            3'b001: n_dec = 3'd6;
            3'b101: enh = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign shift_res = crc_feed(sr_q, {2'b00, data_q[23:20]},
                                enh_q, 3'd4);
    assign flush_res = crc_feed(sr_q, 6'd0, enh_q,
                                enh_q ? 3'd6 : 3'd4);
    assign last_nib  = (cnt_q == n_q - 3'd1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_crc) begin
                    state_d = legal ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (last_nib) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            cnt_q   <= 3'd0;
            n_q     <= 3'd0;
            enh_q   <= 1'b0;
            sr_q    <= 6'd0;
            data_q  <= 24'd0;
            exp_q   <= 6'd0;
            crc_q   <= 6'd0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_crc && legal) begin
                        cnt_q  <= 3'd0;
                        n_q    <= n_dec;
                        enh_q  <= enh;
                        sr_q   <= enh ? SEED6 : {2'b00, SEED4};
                        data_q <= data_algn;
                        exp_q  <= crc_exp;
                    end else if (start_crc) begin
                        crc_q   <= 6'd0;
                        match_q <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr_q   <= shift_res;
                    data_q <= {data_q[19:0], 4'd0};
                    cnt_q  <= cnt_q + 3'd1;
                end
                FLUSH: begin
                    sr_q    <= flush_res;
                    crc_q   <= flush_res;
                    match_q <= (flush_res == exp_q);
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy_crc  = (state_q != IDLE);
    assign done_crc  = (state_q == DONE);
    assign crc_gen   = crc_q;
    assign crc_match = match_q;
    assign mode_err  = err_q;

endmodule
